// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection phase scheduler:
// state encodings, lamp one-hot patterns and the phase timer width.
package traffic_pkg;

    localparam int TIMER_W = 5;

    typedef logic [TIMER_W-1:0] timer_t;

    typedef enum logic [2:0] {
        HW_GREEN  = 3'd0,
        HW_YELLOW = 3'd1,
        ALL_RED_A = 3'd2,
        ST_GREEN  = 3'd3,
        ST_YELLOW = 3'd4,
        PED_WALK  = 3'd5,
        ALL_RED_B = 3'd6
    } state_t;

    // Which conflicting request was granted most recently.
    typedef enum logic {
        SERVED_STREET = 1'b0,
        SERVED_PED    = 1'b1
    } served_t;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    typedef struct packed {
        logic [2:0] highway;
        logic [2:0] street;
        logic       walk;
    } lamps_t;

    // Lamp pattern shown while in a given state.
    function automatic lamps_t lamps_for(state_t s);
        lamps_t l;
        l.highway = LAMP_RED;
        l.street  = LAMP_RED;
        l.walk    = 1'b0;
        case (s)
            HW_GREEN:  l.highway = LAMP_GREEN;
            HW_YELLOW: l.highway = LAMP_YELLOW;
            ST_GREEN:  l.street  = LAMP_GREEN;
            ST_YELLOW: l.street  = LAMP_YELLOW;
            PED_WALK:  l.walk    = 1'b1;
            default:   ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase timer: loads a duration-minus-one on phase entry, counts down to
// zero and parks there until the next load.
module phase_timer
    import traffic_pkg::*;
#(
    parameter timer_t RESET_VALUE = '0
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   load,
    input  timer_t load_value,
    output timer_t value,
    output logic   zero
);

    // Load on phase entry, otherwise decrement and saturate at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= RESET_VALUE;
        end else if (load) begin
            value <= load_value;
        end else if (value != '0) begin
            value <= value - timer_t'(1);
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Highway / side-street / pedestrian phase scheduler.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   HW_GREEN  | highway green, at least T_MIN_GREEN; holds until a request
//   HW_YELLOW | highway yellow, T_YELLOW
//   ALL_RED_A | clearance before granting street or pedestrians
//   ST_GREEN  | street green, T_MIN_GREEN..T_MAX_GREEN depending on car_req
//   ST_YELLOW | street yellow, T_YELLOW
//   PED_WALK  | walk lamp on, all traffic red, T_WALK
//   ALL_RED_B | clearance before returning to highway green
//
// Durations must lie in 1..31 with T_MAX_GREEN >= T_MIN_GREEN.
module intersection_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int T_MIN_GREEN = 10,
    parameter int T_MAX_GREEN = 20,
    parameter int T_YELLOW    = 3,
    parameter int T_ALL_RED   = 1,
    parameter int T_WALK      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       car_req,
    input  logic       ped_req,
    input  logic       emerg,
    output logic [2:0] highway,
    output logic [2:0] street,
    output logic       walk,
    output logic [4:0] countdown,
    output logic [2:0] phase
);

    localparam timer_t LD_MIN_GREEN = timer_t'(T_MIN_GREEN - 1);
    localparam timer_t LD_MAX_GREEN = timer_t'(T_MAX_GREEN - 1);
    localparam timer_t LD_YELLOW    = timer_t'(T_YELLOW - 1);
    localparam timer_t LD_ALL_RED   = timer_t'(T_ALL_RED - 1);
    localparam timer_t LD_WALK      = timer_t'(T_WALK - 1);
    // Street green has lasted at least T_MIN_GREEN cycles once the timer
    // has fallen to this value or below.
    localparam timer_t ST_MIN_DONE  = timer_t'(T_MAX_GREEN - T_MIN_GREEN);

    state_t  state;
    state_t  next_state;
    served_t last_served;
    logic    ped_pend;
    timer_t  timer_value;
    logic    timer_zero;
    logic    load;
    timer_t  load_value;
    lamps_t  next_lamps;

    function automatic timer_t load_for(state_t s);
        timer_t v;
        case (s)
            HW_GREEN:  v = LD_MIN_GREEN;
            HW_YELLOW: v = LD_YELLOW;
            ST_GREEN:  v = LD_MAX_GREEN;
            ST_YELLOW: v = LD_YELLOW;
            PED_WALK:  v = LD_WALK;
            default:   v = LD_ALL_RED;
        endcase
        return v;
    endfunction

    // Next-phase decision from the current phase, timer and requests.
    always_comb begin
        next_state = state;
        unique case (state)
            HW_GREEN: begin
                if (timer_zero && !emerg && (car_req || ped_pend))
                    next_state = HW_YELLOW;
            end
            HW_YELLOW: begin
                if (timer_zero) next_state = ALL_RED_A;
            end
            ALL_RED_A: begin
                if (timer_zero) begin
                    if (emerg)
                        next_state = ALL_RED_B;
                    else if (car_req && ped_pend)
                        next_state = (last_served == SERVED_PED) ? ST_GREEN : PED_WALK;
                    else if (car_req)
                        next_state = ST_GREEN;
                    else if (ped_pend)
                        next_state = PED_WALK;
                    else
                        next_state = ALL_RED_B;
                end
            end
            ST_GREEN: begin
                if (emerg || timer_zero || (!car_req && timer_value <= ST_MIN_DONE))
                    next_state = ST_YELLOW;
            end
            ST_YELLOW: begin
                if (timer_zero) next_state = ALL_RED_B;
            end
            PED_WALK: begin
                if (emerg || timer_zero) next_state = ALL_RED_B;
            end
            ALL_RED_B: begin
                if (timer_zero) next_state = HW_GREEN;
            end
            default: next_state = HW_GREEN;
        endcase
    end

    // Every transition is a phase entry, so the timer reloads exactly then.
    assign load       = (next_state != state);
    assign load_value = load_for(next_state);
    assign next_lamps = lamps_for(next_state);

    phase_timer #(
        .RESET_VALUE (LD_MIN_GREEN)
    ) u_phase_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .value      (timer_value),
        .zero       (timer_zero)
    );

    // Phase register, request latch, fairness memory and registered lamps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= HW_GREEN;
            ped_pend    <= 1'b0;
            last_served <= SERVED_PED;
            highway     <= LAMP_GREEN;
            street      <= LAMP_RED;
            walk        <= 1'b0;
        end else begin
            state <= next_state;
            // A press arriving on the very cycle the walk starts is kept.
            if (load && next_state == PED_WALK)
                ped_pend <= ped_req;
            else
                ped_pend <= ped_pend | ped_req;
            if (load && next_state == ST_GREEN)
                last_served <= SERVED_STREET;
            else if (load && next_state == PED_WALK)
                last_served <= SERVED_PED;
            highway <= next_lamps.highway;
            street  <= next_lamps.street;
            walk    <= next_lamps.walk;
        end
    end

    assign countdown = timer_value;
    assign phase     = state;

endmodule

// File: doc/intersection_phase_scheduler.md
INTERSECTION_PHASE_SCHEDULER -- requirements
Module: intersection_phase_scheduler

Interface
REQ-001 Parameter T_MIN_GREEN, 10, minimum highway/street green length in cycles.
REQ-002 Parameter T_MAX_GREEN, 20, maximum street green length in cycles.
REQ-003 Parameter T_YELLOW, 3, yellow length in cycles.
REQ-004 Parameter T_ALL_RED, 1, all-red clearance length in cycles.
REQ-005 Parameter T_WALK, 8, pedestrian walk length in cycles.
REQ-006 All duration parameters SHALL be in the range 1..31; T_MAX_GREEN >= T_MIN_GREEN.
REQ-007 clk  in  1  single clock; all state changes on its rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 car_req  in  1  street car present, already synchronised to clk, level.
REQ-010 ped_req  in  1  pedestrian button, synchronised to clk, any length pulse.
REQ-011 emerg  in  1  emergency preempt to highway, synchronised, level.
REQ-012 highway  out  3  highway lamps {red,yellow,green}, one-hot.
REQ-013 street  out  3  street lamps {red,yellow,green}, one-hot.
REQ-014 walk  out  1  pedestrian walk lamp.
REQ-015 countdown  out  5  remaining cycles of the current phase minus one, for the two-digit display.
REQ-016 phase  out  3  current state encoding, for debug and display.

Function
REQ-017 States: HW_GREEN, HW_YELLOW, ALL_RED_A, ST_GREEN, ST_YELLOW, PED_WALK, ALL_RED_B.
REQ-018 Lamps: HW_GREEN hw=001/st=100; HW_YELLOW hw=010/st=100; ST_GREEN hw=100/st=001; ST_YELLOW hw=100/st=010; ALL_RED_*, PED_WALK both 100; walk=1 only in PED_WALK.
REQ-019 On state entry, the timer loads duration-1; it decrements each cycle; a timed phase of duration N occupies exactly N cycles; countdown equals the timer value.
REQ-020 ped_pend sets on ped_req=1 and clears on entry to PED_WALK; if ped_req=1 on the entry cycle, ped_pend stays set.
REQ-021 HW_GREEN: once the timer is 0, leave for HW_YELLOW if (car_req or ped_pend) and emerg=0; otherwise hold with the timer at 0.
REQ-022 HW_YELLOW -> ALL_RED_A on timer 0.
REQ-023 ALL_RED_A on timer 0: if both ped_pend and car_req, serve the one not in last_served; if only one is pending, serve it; if neither is pending or emerg=1, go to ALL_RED_B.
REQ-024 ST_GREEN duration is T_MAX_GREEN; it exits early to ST_YELLOW when car_req=0 and at least T_MIN_GREEN cycles have elapsed.
REQ-025 ST_YELLOW -> ALL_RED_B on timer 0; PED_WALK -> ALL_RED_B on timer 0; ALL_RED_B -> HW_GREEN on timer 0.
REQ-026 last_served updates to STREET on entry to ST_GREEN and to PED on entry to PED_WALK.
REQ-027 emerg=1 in ST_GREEN forces ST_YELLOW next cycle; in PED_WALK it forces ALL_RED_B next cycle; yellow and all-red phases always complete.
REQ-028 emerg=1 in HW_GREEN holds HW_GREEN regardless of requests; requests stay latched and are served after emerg falls.
REQ-029 Highway and street SHALL never be simultaneously non-red; walk=1 implies both red.

Reset
REQ-030 While reset=0: state=HW_GREEN, timer=T_MIN_GREEN-1, ped_pend=0, last_served=PED, highway=001, street=100, walk=0, countdown=T_MIN_GREEN-1.
REQ-031 Reset asserted mid-phase SHALL take effect immediately, without waiting for a clock edge; operation resumes from HW_GREEN on the first edge after release.

Structure
REQ-032 traffic_pkg SHALL hold the state encodings, the lamp one-hot constants (RED=100, YELLOW=010, GREEN=001) and the timer width (5).
REQ-033 One sub-module, phase_timer: 5-bit load/decrement counter with a zero flag.
REQ-034 Outputs SHALL be registered or decoded from state only, with no combinational path from inputs.

Verification
REQ-035 Reset, car_req=0, ped_req=0 for 50 cycles -> hw=001 stays, countdown 9..0 then holds at 0.
REQ-036 car_req=1 from cycle 0 -> HW_GREEN 10 cycles, HW_YELLOW 3, ALL_RED_A 1, ST_GREEN 20 (car held), ST_YELLOW 3, ALL_RED_B 1, HW_GREEN.
REQ-037 1-cycle ped_req at cycle 2 with car_req=0 -> PED_WALK entered at cycle 14, walk=1 for 8 cycles, ped_pend cleared.
REQ-038 car_req=1 with ped_req pulsed every highway phase -> ST_GREEN and PED_WALK alternate, street served first after reset.
REQ-039 emerg=1 on the 5th ST_GREEN cycle -> ST_YELLOW next cycle, then all-red, then HW_GREEN held until emerg=0.
REQ-040 reset=0 pulsed mid ST_YELLOW -> outputs go to the reset values with no clock edge, and the lamp-conflict assertion never fires.
